// File: rtl/ntt_pkg.sv
// Shared constants and the loader state encoding for the NTT front end.
//   NttN  : coefficients per polynomial
//   NttQ  : modulus q
//   NttDw : memory data width
//   NttAw : memory address width
package ntt_pkg;

   localparam int unsigned NttN  = 256;
   localparam int unsigned NttQ  = 8380417;
   localparam int unsigned NttDw = 24;
   localparam int unsigned NttAw = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StFlush,
      StStart,
      StWait,
      StFin
   } loader_state_e;

endpackage

// File: rtl/coeff_mod_norm.sv
// Combinational reduction of a signed coefficient into [0,q).
// Ports:
//   coeff_i      signed two's-complement coefficient, valid range [-q, q]
//   norm_o       normalised value; MSB always 0
//   range_err_o  (LOADER_RANGE_CHECK_EN only) coefficient outside [-q, q]
// Optional feature macro: LOADER_RANGE_CHECK_EN
module coeff_mod_norm #(
   parameter int unsigned DW = 24,
   parameter int unsigned Q  = 8380417
) (
   input  logic [DW-1:0] coeff_i,
`ifdef LOADER_RANGE_CHECK_EN
   output logic          range_err_o,
`endif
   output logic [DW-1:0] norm_o
);

   logic signed [DW:0] d_ext;
   logic signed [DW:0] q_ext;
   logic signed [DW:0] sum;
   logic               unused_sum_msbs;

   assign d_ext = $signed({coeff_i[DW-1], coeff_i});
   assign q_ext = $signed((DW+1)'(Q));

   always_comb begin
      sum = d_ext;
      if (d_ext < 0) begin
         sum = d_ext + q_ext;
      end else if (d_ext >= q_ext) begin
         sum = d_ext - q_ext;
      end
   end

   // Out-of-range inputs still produce a value below 2^(DW-1).
   assign norm_o          = {1'b0, sum[DW-2:0]};
   assign unused_sum_msbs = ^sum[DW:DW-1];

`ifdef LOADER_RANGE_CHECK_EN
   assign range_err_o = (d_ext < -q_ext) || (d_ext > q_ext);
`endif

endmodule

// File: rtl/ntt_coeff_loader.sv
// Streams N signed coefficients into the NTT memory, then starts the NTT and waits for it.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   go                        one-cycle job request, honoured only when idle
//   in_valid/in_data/in_ready coefficient stream (transfer = in_valid & in_ready)
//   load_mem                  loader owns the memory port
//   A_load/D_load/WEB_load    registered memory write port (WEB_load active-low)
//   start_NTT                 one-cycle NTT start pulse
//   done_NTT                  NTT completion level, sampled only while waiting
//   busy                      high whenever not idle
//   done                      one-cycle job-complete pulse
//   err                       (LOADER_RANGE_CHECK_EN only) sticky out-of-range flag
// Optional feature macro: LOADER_RANGE_CHECK_EN
module ntt_coeff_loader
   import ntt_pkg::*;
#(
   parameter int unsigned N         = NttN,
   parameter int unsigned Q         = NttQ,
   parameter int unsigned AW        = NttAw,
   parameter int unsigned DW        = NttDw,
   parameter logic [AW-1:0] BASE_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          load_mem,
   output logic [AW-1:0] A_load,
   output logic [DW-1:0] D_load,
   output logic          WEB_load,
   output logic          start_NTT,
   input  logic          done_NTT,
   output logic          busy,
`ifdef LOADER_RANGE_CHECK_EN
   output logic          err,
`endif
   output logic          done
);

   localparam int unsigned CW = $clog2(N + 1);

   loader_state_e state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          web_q, web_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [DW-1:0] norm_data;
   logic          xfer;

`ifdef LOADER_RANGE_CHECK_EN
   logic          err_q, err_d;
   logic          range_err;
`endif

   coeff_mod_norm #(
      .DW (DW),
      .Q  (Q)
   ) u_norm (
      .coeff_i     (in_data),
`ifdef LOADER_RANGE_CHECK_EN
      .range_err_o (range_err),
`endif
      .norm_o      (norm_data)
   );

   assign in_ready = (state_q == StLoad);
   assign xfer     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      web_d   = 1'b1;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef LOADER_RANGE_CHECK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (go) begin
               state_d = StLoad;
               count_d = '0;
`ifdef LOADER_RANGE_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         StLoad: begin
            if (xfer) begin
               web_d   = 1'b0;
               addr_d  = BASE_ADDR + AW'(count_q);
               data_d  = norm_data;
               count_d = count_q + 1'b1;
`ifdef LOADER_RANGE_CHECK_EN
               if (range_err) begin
                  err_d = 1'b1;
               end
`endif
               if (count_q == CW'(N - 1)) begin
                  state_d = StFlush;
               end
            end
         end
         // Last write is on the port this cycle; keep the memory one more cycle.
         StFlush: state_d = StStart;
         StStart: state_d = StWait;
         StWait: begin
            if (done_NTT) begin
               state_d = StFin;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         web_q   <= 1'b1;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         web_q   <= web_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

`ifdef LOADER_RANGE_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   assign load_mem  = (state_q == StLoad) || (state_q == StFlush);
   assign A_load    = addr_q;
   assign D_load    = data_q;
   assign WEB_load  = web_q;
   assign start_NTT = (state_q == StStart);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFin);

endmodule
